// File: rtl/ps2_rx_frame.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ps2_rx_frame: PS/2 device-to-host frame receiver. Conditions ps2c/ps2d, |
// | deserialises start/8 data/odd parity/stop, flags errors. Rev 1.0       |
// +-----------------------------------------------------------------------+
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic                  c_meta_q, c_s_q, d_meta_q, d_s_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  c_f_q, c_f_d, c_f_dly_q;
  logic                  fall, timeout;
  logic [1:0]            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            sh_q, sh_d, dout_q, dout_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  rx_done_q, rx_done_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;

  // Front end resets to the idle-high line level so release never fakes a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta_q  <= 1'b1;
      c_s_q     <= 1'b1;
      d_meta_q  <= 1'b1;
      d_s_q     <= 1'b1;
      filt_q    <= '1;
      c_f_q     <= 1'b1;
      c_f_dly_q <= 1'b1;
    end else begin
      c_meta_q  <= ps2c;
      c_s_q     <= c_meta_q;
      d_meta_q  <= ps2d;
      d_s_q     <= d_meta_q;
      filt_q    <= filt_d;
      c_f_q     <= c_f_d;
      c_f_dly_q <= c_f_q;
    end
  end

  always_comb begin
    filt_d = {filt_q[FILTER_LEN-2:0], c_s_q};
    c_f_d  = c_f_q;
    if (&filt_q)       c_f_d = 1'b1;
    else if (~|filt_q) c_f_d = 1'b0;
  end

  assign fall    = c_f_dly_q & ~c_f_q;
  assign timeout = (state_q != ST_IDLE) && !fall && (tmo_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      dout_q       <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      dout_q       <= dout_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    tmo_d     = tmo_q + TW'(1);
    if (state_q == ST_IDLE || fall) tmo_d = '0;
    else if (timeout) begin
      tmo_d   = '0;
      state_d = ST_IDLE;
    end
    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          // rx_en only gates the start bit; a frame already underway completes.
          if (rx_en && !d_s_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          sh_d      = {d_s_q, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = d_s_q;
          state_d = ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout_d       = dout_q;
    rx_done_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall && state_q == ST_STOP) begin
      dout_d       = sh_q;
      rx_done_d    = 1'b1;
      parity_err_d = ~(^{sh_q, par_q});
      frame_err_d  = ~d_s_q;
    end else if (timeout) begin
      frame_err_d  = 1'b1;
    end
  end

  assign dout       = dout_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// Bench for ps2_rx_frame: drives PS/2 frames and compares every output pulse
// (cycle, flags, byte) against a frame-level model of the receiver.
module tb_ps2_rx_frame;
  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 30;

  logic       clk = 1'b0, rst_n = 1'b0, ps2c = 1'b1, ps2d = 1'b1, rx_en = 1'b1;
  logic [7:0] dout;
  logic       rx_done, parity_err, frame_err;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .dout(dout), .rx_done(rx_done), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic        done;
    logic        pe;
    logic        fe;
    logic [7:0]  d;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] model_dout = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rx_done === 1'b1 || parity_err === 1'b1 || frame_err === 1'b1)
      ev_q.push_back({32'(cyc), rx_done, parity_err, frame_err, dout});

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives nbits of a frame and records what a PS/2 receiver must report for it:
  // a full frame reports at the stop fall + FL+3, a truncated one times out TO later.
  task automatic send_frame(input logic [7:0] data, input bit par_ok, input bit stop_bit,
                            input int nbits, input int glitch_bit, input int drop_en_bit);
    logic [10:0] bits;
    bit          acc;
    int          last_e0;
    bits    = {stop_bit, (par_ok ? ~^data : ^data), data, 1'b0};
    acc     = 1'b0;
    last_e0 = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      if (i == glitch_bit) begin
        tick(10); ps2c = 1'b0; tick(FL - 1); ps2c = 1'b1; tick(HALF - 10 - (FL - 1));
      end else begin
        tick(HALF);
      end
      ps2c    = 1'b0;
      last_e0 = cyc + 1;
      if (i == 0) acc = rx_en && !bits[0];
      tick(HALF);
      ps2c = 1'b1;
      if (i == drop_en_bit) rx_en = 1'b0;
    end
    ps2d = 1'b1;
    if (acc && nbits == 11) begin
      exp_q.push_back({32'(last_e0 + FL + 3), 1'b1, ~(^data ^ bits[9]), ~bits[10], data});
      model_dout = data;
    end else if (acc && nbits > 0) begin
      exp_q.push_back({32'(last_e0 + FL + 3 + TO), 1'b0, 1'b0, 1'b1, model_dout});
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_cmp++;
    if ({dout, rx_done, parity_err, frame_err} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_values: got dout=%h done=%b pe=%b fe=%b, expected 00/0/0/0",
               dout, rx_done, parity_err, frame_err);
    end
    rst_n = 1'b1;
    tick(40);
    n_cmp++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_release: got %0d pulses, expected 0", ev_q.size());
    end
  endtask

  task automatic test_good_frame;
    ev_q.delete(); exp_q.delete();
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1, -1);
    tick(FL + 10);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL good_frame count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL good_frame ev%0d: got cyc=%0d dpf=%b%b%b dout=%h, expected cyc=%0d dpf=%b%b%b dout=%h",
                 i, ev_q[i].cyc, ev_q[i].done, ev_q[i].pe, ev_q[i].fe, ev_q[i].d,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
      end
    end
  endtask

  task automatic test_errors;
    ev_q.delete(); exp_q.delete();
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1, -1);
    tick(FL + 10);
    send_frame(8'h12, 1'b1, 1'b0, 11, -1, -1);
    tick(FL + 10);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL errors count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL errors ev%0d: got cyc=%0d dpf=%b%b%b dout=%h, expected cyc=%0d dpf=%b%b%b dout=%h",
                 i, ev_q[i].cyc, ev_q[i].done, ev_q[i].pe, ev_q[i].fe, ev_q[i].d,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
      end
    end
  endtask

  task automatic test_timeout;
    ev_q.delete(); exp_q.delete();
    send_frame(8'h9B, 1'b1, 1'b1, 5, -1, -1);
    tick(TO + FL + 20);
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, -1);
    tick(FL + 10);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL timeout count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout ev%0d: got cyc=%0d dpf=%b%b%b dout=%h, expected cyc=%0d dpf=%b%b%b dout=%h",
                 i, ev_q[i].cyc, ev_q[i].done, ev_q[i].pe, ev_q[i].fe, ev_q[i].d,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
      end
    end
  endtask

  task automatic test_glitch;
    ev_q.delete(); exp_q.delete();
    ps2d = 1'b0;
    tick(10); ps2c = 1'b0; tick(FL - 1); ps2c = 1'b1; tick(30);
    ps2d = 1'b1;
    send_frame(8'hAA, 1'b1, 1'b1, 11, 4, -1);
    tick(FL + 10);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL glitch count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL glitch ev%0d: got cyc=%0d dpf=%b%b%b dout=%h, expected cyc=%0d dpf=%b%b%b dout=%h",
                 i, ev_q[i].cyc, ev_q[i].done, ev_q[i].pe, ev_q[i].fe, ev_q[i].d,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
      end
    end
  endtask

  task automatic test_rx_en;
    ev_q.delete(); exp_q.delete();
    rx_en = 1'b0;
    send_frame(8'h33, 1'b1, 1'b1, 11, -1, -1);
    tick(FL + 10);
    rx_en = 1'b1;
    send_frame(8'h44, 1'b1, 1'b1, 11, -1, 3);
    tick(FL + 10);
    rx_en = 1'b1;
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rx_en count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rx_en ev%0d: got cyc=%0d dpf=%b%b%b dout=%h, expected cyc=%0d dpf=%b%b%b dout=%h",
                 i, ev_q[i].cyc, ev_q[i].done, ev_q[i].pe, ev_q[i].fe, ev_q[i].d,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
      end
    end
    n_cmp++;
    if (dout !== model_dout) begin
      n_fail++;
      $display("FAIL rx_en dout: got %h, expected %h", dout, model_dout);
    end
  endtask

  task automatic test_reset_mid;
    ev_q.delete(); exp_q.delete();
    send_frame(8'h77, 1'b1, 1'b1, 9, -1, -1);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dout, rx_done, parity_err, frame_err} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got dout=%h done=%b pe=%b fe=%b, expected 00/0/0/0",
               dout, rx_done, parity_err, frame_err);
    end
    // The partial frame is discarded, so its predicted timeout never happens.
    exp_q.delete();
    model_dout = 8'h00;
    tick(5);
    rst_n = 1'b1;
    tick(TO + 20);
    send_frame(8'h29, 1'b1, 1'b1, 11, -1, -1);
    tick(FL + 10);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_mid count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid ev%0d: got cyc=%0d dpf=%b%b%b dout=%h, expected cyc=%0d dpf=%b%b%b dout=%h",
                 i, ev_q[i].cyc, ev_q[i].done, ev_q[i].pe, ev_q[i].fe, ev_q[i].d,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
      end
    end
  endtask

  task automatic test_random;
    int nb;
    ev_q.delete(); exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 11;
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), nb,
                 ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 10)), -1);
      tick((nb == 11) ? FL + 10 : TO + FL + 20);
    end
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random ev%0d: got cyc=%0d dpf=%b%b%b dout=%h, expected cyc=%0d dpf=%b%b%b dout=%h",
                 i, ev_q[i].cyc, ev_q[i].done, ev_q[i].pe, ev_q[i].fe, ev_q[i].d,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
      end
    end
    n_cmp++;
    if (dout !== model_dout) begin
      n_fail++;
      $display("FAIL random dout: got %h, expected %h", dout, model_dout);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_timeout();
    test_glitch();
    test_rx_en();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

Receives PS/2 device-to-host frames: conditions the raw `ps2c`/`ps2d` lines, detects falling clock edges, and deserialises the 11-bit frame (start, 8 data LSB-first, odd parity, stop). The block emits the data byte with a one-cycle `rx_done` strobe, plus separate one-cycle error pulses. It sits directly upstream of the scan-code decoder. Its `parity_err` and `frame_err` pulses feed the 2-input OR that forms the combined receive-error flag.

## Interface
- `FILTER_LEN`, 8: glitch-filter depth in clk cycles (≥2).
- `TIMEOUT_CYC`, 5000: idle clk cycles allowed between PS/2 falling edges inside a frame (100 µs at 50 MHz).
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2c` input 1: raw PS/2 clock line, asynchronous.
- `ps2d` input 1: raw PS/2 data line, asynchronous.
- `rx_en` input 1: allows a new frame to start.
- `dout` output 8: last received byte.
- `rx_done` output 1: one-cycle pulse; frame complete, `dout` valid.
- `parity_err` output 1: one-cycle pulse coincident with `rx_done` on odd-parity failure.
- `frame_err` output 1: one-cycle pulse on stop-bit error or timeout.

## Operation
- **Synchronisers.** `ps2c` and `ps2d` each pass through 2 flops (`c_s`, `d_s`).
- **Glitch filter.** `c_s` shifts into a `FILTER_LEN`-bit register.
  - Filtered level `c_f` is registered: it goes to 1 when the register is all ones, 0 when all zeros, and otherwise holds.
- **Edge detect.** `fall` = `c_f` delayed one cycle AND NOT `c_f`. It is high for exactly one cycle per filtered falling edge.
- **Data sampling.** `d_s` is sampled in the cycle where `fall` = 1.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - **IDLE:** on `fall` with `rx_en`=1 and sample 0, go to DATA with bit count 0.
    - A sample of 1, or `rx_en`=0, is ignored and the FSM stays in IDLE.
  - **DATA:** on each `fall`, shift right: `sh <= {d, sh[7:1]}` and increment the count. After the 8th bit, go to PARITY.
  - **PARITY:** on `fall`, store the parity bit and go to STOP.
  - **STOP:** on `fall`:
    - `dout <= sh` and pulse `rx_done`.
    - Pulse `parity_err` if XOR(sh, parity) ≠ 1.
    - Pulse `frame_err` if the stop sample is 0.
    - Go to IDLE.
  - `rx_done` pulses regardless of errors; the error pulses qualify it.
- **Timeout.** The counter clears on every `fall` and in IDLE, and increments in other states.
  - If it reaches `TIMEOUT_CYC`-1 with no `fall`, pulse `frame_err` (without `rx_done`) and go to IDLE. `dout` is unchanged.
  - Counter width is ceil(log2(`TIMEOUT_CYC`)).
- **`rx_en` dropping mid-frame.** This does not abort; the frame in progress completes normally.
- **Simultaneous `fall` and timeout terminal count.** `fall` wins; the counter clears.

## Timing
- **Reset values:**
  - `dout`=0x00, `rx_done`=0, `parity_err`=0, `frame_err`=0.
  - FSM=IDLE, counters 0.
  - Synchroniser and filter registers = 1, so `c_f`=1 and there is no spurious `fall` after reset.
- **Reset mid-frame.** Asserting `rst_n`=0 forces all of the above immediately and asynchronously. The partial frame is discarded, with no pulses.
- **Latency.** The first clk edge sampling a stable low `ps2c` is edge 0. `fall` is high after edge `FILTER_LEN`+2. The FSM acts, and registered outputs (`rx_done`, `dout`, error pulses) change, on edge `FILTER_LEN`+3.
- **Output timing.** All outputs are registered. Each pulse is exactly 1 cycle wide. `dout` holds until the next `rx_done`.
- **Glitch rejection.** Any `ps2c` low or high excursion shorter than `FILTER_LEN` cycles produces no `fall`.
- **Setup/hold.** `ps2d` must be stable for 2 cycles before through `FILTER_LEN`+3 cycles after the raw `ps2c` fall. The PS/2 protocol guarantees this by a wide margin.

## Test plan
- **Good frame.** Send byte 0x1C (parity bit 0, stop 1) with a 12.5 kHz `ps2c`, `rx_en`=1.
  - Required: one `rx_done` pulse, `dout`=0x1C, `parity_err`=0, `frame_err`=0, pulse `FILTER_LEN`+3 cycles after the stop-bit fall.
- **Parity and stop errors.** Send 0xF0 with parity bit 0 (wrong) → `rx_done`=1 and `parity_err`=1 in the same cycle, `dout`=0xF0. Then send 0x12 with stop bit 0 → `rx_done`=1 with `frame_err`=1.
- **Timeout.** Stop `ps2c` after 4 data bits.
  - Required: `frame_err` pulses exactly `TIMEOUT_CYC` cycles after the last `fall`, no `rx_done`, `dout` keeps its previous value.
  - A following good frame 0x5A is received correctly.
- **Glitch rejection.** Insert `FILTER_LEN`-1-cycle low glitches on `ps2c` while idle and mid-frame → no extra bits; 0xAA is received correctly.
- **`rx_en` gating.** With `rx_en`=0, send 0x33 → no pulses. Then set `rx_en`=1, start 0x44, and drop `rx_en` after bit 3 → `rx_done` with `dout`=0x44.
- **Reset mid-frame.** Assert `rst_n`=0 during PARITY.
  - Required: outputs 0x00/0/0/0 immediately, no pulses.
  - After release, a good frame 0x29 is received; no spurious `fall` at release.
